// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control stage: FSM encoding and
// the prescaler divide-ratio helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/stopwatch_control_debounce_edge.sv
// Button conditioner: 2-flop synchronizer, stable-count debouncer and a
// registered rising-edge press pulse.
module debounce_edge #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0_q, sync1_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synced level matches the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync1_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync0_q      <= 1'b0;
      sync1_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync0_q      <= raw;
      sync1_q      <= sync0_q;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control stage: debounced start/stop and clear buttons drive a
// IDLE/RUNNING/PAUSED FSM and a prescaler that emits the seconds tick.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic btn_startstop,
  input  logic btn_clear,
  output logic tick,
  output logic run,
  output logic clear
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic ss_level, ss_press;
  logic clr_level, clr_press;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             clear_q, clear_d;
  logic             run_q;

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (btn_startstop),
    .level (ss_level),
    .press (ss_press)
  );

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (btn_clear),
    .level (clr_level),
    .press (clr_press)
  );

  // Clear has priority over a simultaneous start/stop press.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    if (clr_press) begin
      state_d = IDLE;
      clear_d = 1'b1;
    end else if (ss_press) begin
      case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end
  end

  // Advance only while staying in RUNNING, so a pause/resume edge keeps the fraction.
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (state_d == IDLE) begin
      pre_d = '0;
    end else if (state_q == RUNNING && state_d == RUNNING) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      clear_q <= clear_d;
      run_q   <= (state_d == RUNNING);
    end
  end

  assign tick  = tick_q;
  assign run   = run_q;
  assign clear = clear_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control: expected output events (tick, run edges,
// clear) are queued with their cycle numbers and matched by a monitor.
module tb_stopwatch_control;

  localparam int CLK_HZ = 20;
  localparam int TICK_HZ = 1;
  localparam int DB = 4;
  localparam int DIV = CLK_HZ / TICK_HZ;
  // Input driven at negedge d is first sampled at edge d+1; run changes on
  // the (DB+4)th edge counting that one.
  localparam int PRESS_LAT = DB + 4;

  logic Clock = 1'b0;
  logic Reset;
  logic btn_startstop;
  logic btn_clear;
  logic tick, run, clear;

  typedef struct {
    int kind;
    int c;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   running = 1'b0;
  int   anchor = 0;
  logic run_prev = 1'b0;
  logic [3:0] seen;

  stopwatch_control #(
    .CLK_HZ          (CLK_HZ),
    .TICK_HZ         (TICK_HZ),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .btn_startstop (btn_startstop),
    .btn_clear     (btn_clear),
    .tick          (tick),
    .run           (run),
    .clear         (clear)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  function automatic string kname(input int k);
    case (k)
      0:       return "tick";
      1:       return "run_rise";
      2:       return "run_fall";
      default: return "clear";
    endcase
  endfunction

  always @(negedge Clock) begin
    if (!Reset) begin
      seen = {clear, run_prev & ~run, ~run_prev & run, tick};
      for (int k = 0; k < 4; k++) begin
        if (seen[k]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event %s at cycle %0d: got unexpected event, required none", kname(k), cyc);
          end else if (exp_q[0].kind != k || exp_q[0].c != cyc) begin
            n_fail++;
            $display("FAIL event %s at cycle %0d: required next %s at cycle %0d",
                     kname(k), cyc, kname(exp_q[0].kind), exp_q[0].c);
          end else begin
            void'(exp_q.pop_front());
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing %s: required at cycle %0d, absent by cycle %0d",
                 kname(exp_q[0].kind), exp_q[0].c, cyc);
        void'(exp_q.pop_front());
      end
    end
    run_prev = run;
  end

  task automatic push_exp(input int k, input int c);
    int i = 0;
    ev_t e;
    e.kind = k;
    e.c = c;
    while (i < exp_q.size() && (exp_q[i].c < c || (exp_q[i].c == c && exp_q[i].kind <= k))) i++;
    exp_q.insert(i, e);
  endtask

  // Queue the ticks due in the next n cycles, then let them elapse.
  task automatic advance(input int n);
    int stop = cyc + n;
    if (running) begin
      for (int c = cyc + 1; c <= stop; c++)
        if (c >= anchor && (c - anchor) % DIV == 0) push_exp(0, c);
    end
    while (cyc < stop) @(negedge Clock);
  endtask

  task automatic align_to_tick();
    int t = anchor + ((cyc - anchor) / DIV + 1) * DIV;
    advance(t - cyc);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    btn_startstop = 1'b0;
    btn_clear = 1'b0;
    #1;
    n_checks++;
    if ({tick, run, clear} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state: got tick/run/clear=%b, required 000", {tick, run, clear});
    end
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      n_checks++;
      if ({tick, run, clear} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d: got tick/run/clear=%b, required 000", cyc, {tick, run, clear});
      end
    end
  endtask

  task automatic test_start_tick();
    int r;
    r = cyc + PRESS_LAT;
    push_exp(1, r);
    running = 1'b1;
    anchor = r + DIV;
    btn_startstop = 1'b1;
    advance(12);
    btn_startstop = 1'b0;
    advance(r + 3 * DIV + 1 - cyc);
    n_checks++;
    if (run !== 1'b1) begin
      n_fail++;
      $display("FAIL start_run: got run=%b, required 1", run);
    end
  endtask

  task automatic test_glitch();
    btn_startstop = 1'b1;
    advance(3);
    btn_startstop = 1'b0;
    advance(5);
    btn_startstop = 1'b1;
    advance(2);
    btn_startstop = 1'b0;
    advance(20);
    n_checks++;
    if (run !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_run: got run=%b, required 1", run);
    end
  endtask

  task automatic test_pause_resume();
    int p, r2;
    align_to_tick();
    // Prescaler reads 7 just before the pause edge.
    p = cyc + PRESS_LAT;
    push_exp(2, p);
    running = 1'b0;
    btn_startstop = 1'b1;
    advance(8);
    btn_startstop = 1'b0;
    advance(50);
    n_checks++;
    if (run !== 1'b0) begin
      n_fail++;
      $display("FAIL paused_run: got run=%b, required 0", run);
    end
    r2 = cyc + PRESS_LAT;
    push_exp(1, r2);
    running = 1'b1;
    anchor = r2 + DIV - 7;
    btn_startstop = 1'b1;
    advance(8);
    btn_startstop = 1'b0;
    advance(anchor + DIV + 1 - cyc);
    n_checks++;
    if (run !== 1'b1) begin
      n_fail++;
      $display("FAIL resumed_run: got run=%b, required 1", run);
    end
  endtask

  task automatic test_clear_wins();
    int e, r;
    align_to_tick();
    e = cyc + PRESS_LAT;
    push_exp(2, e);
    push_exp(3, e);
    running = 1'b0;
    btn_startstop = 1'b1;
    btn_clear = 1'b1;
    advance(8);
    btn_startstop = 1'b0;
    btn_clear = 1'b0;
    advance(20);
    n_checks++;
    if ({run, clear} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_idle: got run/clear=%b, required 00", {run, clear});
    end
    // Restart from IDLE: a full DIV to the first tick shows the prescaler was zeroed.
    r = cyc + PRESS_LAT;
    push_exp(1, r);
    running = 1'b1;
    anchor = r + DIV;
    btn_startstop = 1'b1;
    advance(8);
    btn_startstop = 1'b0;
    advance(anchor + 1 - cyc);
  endtask

  task automatic test_reset_mid();
    int r;
    advance(anchor + 15 - cyc);
    n_checks++;
    if (run !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_run: got run=%b, required 1", run);
    end
    #2;
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({tick, run, clear} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got tick/run/clear=%b, required 000", {tick, run, clear});
    end
    running = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    advance(5);
    r = cyc + PRESS_LAT;
    push_exp(1, r);
    running = 1'b1;
    anchor = r + DIV;
    btn_startstop = 1'b1;
    advance(8);
    btn_startstop = 1'b0;
    advance(anchor + DIV + 1 - cyc);
    n_checks++;
    if (run !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_run: got run=%b, required 1", run);
    end
  endtask

  initial begin
    test_reset();
    test_start_tick();
    test_glitch();
    test_pause_resume();
    test_clear_wins();
    test_reset_mid();
    advance(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending events, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stopwatch_control.md
Name: stopwatch_control

Overview:
Upstream control stage for the stopwatch digit counters.
- Converts two raw push-buttons (start/stop, clear) into clean control signals.
- Generates the 1 Hz seconds tick from the board clock.
- Outputs map onto the counter chain: `tick` drives the seconds-units counter clock, `run` drives Enable, `clear` drives the counters' Reset.

Parameters:
- CLK_HZ, 50000000, board clock frequency in Hz.
- TICK_HZ, 1, tick rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be >= 2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new button level (20 ms at 50 MHz); must be >= 1.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- btn_startstop  input  1  raw, asynchronous, bouncing start/stop button, active-high.
- btn_clear  input  1  raw, asynchronous, bouncing clear button, active-high.
- tick  output  1  one-Clock-cycle pulse per 1/TICK_HZ while running.
- run  output  1  high while in state RUNNING.
- clear  output  1  one-cycle pulse when a clear press is accepted.

Behaviour:
- Interface: reset Reset, asynchronous, active-high; clock Clock. All flops reset asynchronously.
- Reset values:
  - tick=0, run=0, clear=0.
  - State IDLE.
  - Synchronizer flops, debounced levels, debounce counters and prescaler all 0.
- Input path, per button:
  - 2-flop synchronizer.
  - Debounce counter of width $clog2(DEBOUNCE_CYCLES+1). Increments each cycle the synced level differs from the debounced level; clears to 0 on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level toggles on the next edge and the counter clears.
  - Rising edge of the debounced level produces a registered 1-cycle press pulse. Releases produce nothing.
- Latency: from the first Clock edge that samples a button high (held stable) to the `run` change is exactly DEBOUNCE_CYCLES+4 edges.
- FSM states: IDLE (stopped at zero), RUNNING, PAUSED.
  - IDLE + ss_press -> RUNNING.
  - RUNNING + ss_press -> PAUSED.
  - PAUSED + ss_press -> RUNNING.
  - Any state + clr_press -> IDLE; clear=1 for exactly that one cycle (registered, same edge as the state change).
  - clr_press and ss_press in the same cycle: clear wins, result is IDLE; the start/stop press is discarded.
  - Holding a button produces a single press; the next press needs release plus re-press, each debounced.
- Prescaler, width $clog2(DIV):
  - RUNNING: counts 0..DIV-1 and wraps to 0. tick=1 (registered) on the cycle the prescaler wraps.
  - PAUSED: holds its value, so the fractional second is preserved; tick=0.
  - IDLE or clear: forced to 0.
  - The first tick after IDLE->RUNNING occurs exactly DIV cycles after `run` rises.
- Outputs are glitch-free registered signals; run = (state==RUNNING).
- Reset mid-operation: outputs go to their reset values immediately, without a clock edge. Operation resumes from IDLE after deassertion.

Decomposition:
- Shared package (stopwatch_pkg):
  - FSM state encoding localparams: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2.
  - Derived DIV constant helper.
- Sub-module debounce_edge (parameter DEBOUNCE_CYCLES; ports Clock, Reset, raw, level, press). Instantiated twice.
- FSM and prescaler live in the top module.

Test Plan:
All scenarios use bench parameters CLK_HZ=20, TICK_HZ=1 (DIV=20) and DEBOUNCE_CYCLES=4.
1. Assert Reset, release, idle 100 cycles -> tick, run and clear stay 0 throughout.
2. btn_startstop high 12 cycles -> run rises exactly 8 edges after first high sample. tick pulses every 20 cycles, first at 20 cycles after run rises, each pulse 1 cycle wide.
3. btn_startstop glitch high 3 cycles, low 5, high 2 -> no press accepted; run and state unchanged.
4. Running, press start/stop when prescaler=7, wait 50 cycles, press again -> no tick while paused. First tick after resume comes 13 cycles after run re-rises.
5. Running, btn_clear and btn_startstop rise on the same cycle, both held 8 cycles -> single 1-cycle clear pulse, state IDLE, run=0, prescaler=0, no tick.
6. Running with prescaler=15, assert Reset between clock edges -> tick, run and clear read 0 before the next edge. After release, btn_startstop press restarts and the first tick comes 20 cycles after run rises.
